// File: rtl/hybrid_adder_seq_ctrl.sv
// Multi-byte add/subtract sequencer: drives one external 8-bit adder a byte per cycle,
// LSB first, chaining the adder's C8 back into C0 of the next byte.
module hybrid_adder_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [8*NBYTES-1:0]   req_a,
  input  logic [8*NBYTES-1:0]   req_b,
  input  logic                  req_sub,
  input  logic                  req_cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [8*NBYTES-1:0]   rsp_sum,
  output logic                  rsp_cout,
  output logic                  rsp_ovf,
  output logic                  busy,
  output logic [7:0]            adder_x,
  output logic [7:0]            adder_y,
  output logic                  adder_c0,
  input  logic [7:0]            adder_s,
  input  logic                  adder_c8
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
  // req_ready is high only in IDLE; rsp_valid is high only in DONE and the result
  // holds stable until rsp_ready is seen, with no combinational path ready->valid.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            // Subtract is A + ~B + ~borrow, so B is inverted once here at accept.
            a_q   <= req_a;
            b_q   <= req_b ^ {W{req_sub}};
            carry <= req_cin ^ req_sub;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_q[8*idx +: 8] <= adder_s;
          carry             <= adder_c8;
          idx               <= idx + IW'(1);
          if (idx == IW'(NBYTES - 1)) state <= DONE;
        end
        DONE: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic in_run;
  logic in_done;

  assign in_run    = (state == RUN);
  assign in_done   = (state == DONE);

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = in_done;

  // The adder sees only registered values, so its path is a single reg->reg cycle.
  assign adder_x   = in_run ? a_q[8*idx +: 8] : 8'h00;
  assign adder_y   = in_run ? b_q[8*idx +: 8] : 8'h00;
  assign adder_c0  = in_run & carry;

  assign rsp_sum   = in_done ? sum_q : '0;
  assign rsp_cout  = in_done & carry;
  assign rsp_ovf   = in_done & (a_q[W-1] == b_q[W-1]) & (sum_q[W-1] != a_q[W-1]);

endmodule
